// File: rtl/uart_rx_controller.sv
// 16x oversampling UART receiver: start-edge detect, 3-sample majority vote,
// LSB-first deserialization, parity/stop checking and valid/ready delivery.
module uart_rx_controller #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    input  logic [1:0] parity_sel,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int          DATA_W    = 8;
    localparam int          TICK_DIV  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam logic [11:0] TICK_LAST = 12'(TICK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t              state, state_nx;
    logic                sync_p0, sync_p1, sync_p2;
    logic                vld_p0, vld_p1;
    logic                line_armed;
    logic [11:0]         tick_cnt;
    logic                tick;
    logic [3:0]          smp_cnt;
    logic [2:0]          bit_idx;
    logic [1:0]          par_mode;
    logic                smp7, smp8, par_bit;
    logic [DATA_W-1:0]   shift_p0;
    logic                vote, mid_tick, end_tick, start_edge, frame_done;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic exp_parity(input logic [DATA_W-1:0] d, input logic [1:0] mode);
        case (mode)
            2'b01:   return ^d;
            2'b10:   return ~^d;
            default: return 1'b1;
        endcase
    endfunction

    // Synchronizer stage; vld_pN marks samples taken after reset release so a
    // line that is low out of reset cannot look like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            sync_p2    <= 1'b1;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            line_armed <= 1'b0;
        end else begin
            sync_p0 <= rx_serial;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            if (vld_p1 && sync_p1)
                line_armed <= 1'b1;
        end
    end

    assign start_edge = (state == S_IDLE) && line_armed && sync_p2 && !sync_p1;
    assign tick       = (tick_cnt == TICK_LAST);
    assign mid_tick   = tick && (smp_cnt == 4'd9);
    assign end_tick   = tick && (smp_cnt == 4'd15);
    assign vote       = maj3(smp7, smp8, sync_p1);

    // Sample timing stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            smp_cnt  <= '0;
            bit_idx  <= '0;
            par_mode <= '0;
        end else begin
            tick_cnt <= (start_edge || tick) ? 12'd0 : tick_cnt + 12'd1;
            if (start_edge) begin
                smp_cnt  <= '0;
                bit_idx  <= '0;
                par_mode <= parity_sel;
            end else if (tick) begin
                smp_cnt <= smp_cnt + 4'd1;
                if (state == S_DATA && end_tick)
                    bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Capture/deserialize stage
    always_ff @(posedge clk) begin
        if (tick && smp_cnt == 4'd7)
            smp7 <= sync_p1;
        if (tick && smp_cnt == 4'd8)
            smp8 <= sync_p1;
        if (state == S_DATA && mid_tick)
            shift_p0[bit_idx] <= vote;
        if (state == S_PARITY && mid_tick)
            par_bit <= vote;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start_edge) state_nx = S_START;
            S_START: begin
                if (mid_tick && vote)
                    state_nx = S_IDLE;
                else if (end_tick)
                    state_nx = S_DATA;
            end
            S_DATA: begin
                if (end_tick && bit_idx == 3'd7)
                    state_nx = (par_mode != 2'b00) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (end_tick) state_nx = S_STOP;
            S_STOP:   if (mid_tick) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy    = (state != S_IDLE);
        frame_done = (state == S_STOP) && mid_tick;
    end

    // Delivery stage: a completed frame replaces the held byte only if the
    // held byte is empty or being accepted this same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data      <= shift_p0;
                    rx_valid     <= 1'b1;
                    parity_error <= (par_mode != 2'b00) &&
                                    (par_bit != exp_parity(shift_p0, par_mode));
                    frame_error  <= !vote;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: serial frames driven from a
// byte-level reference model, delivered bytes collected by a handshake monitor.
module tb_uart_rx_controller;

    localparam int BAUD     = 115200;
    localparam int CLK_FREQ = BAUD * 16 * 4;
    localparam int BIT      = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_serial = 1'b1;
    logic [1:0] parity_sel = 2'b00;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, parity_error, frame_error, overrun, rx_busy;

    int checks = 0;
    int failures = 0;

    int         cyc = 0;
    int         got_cnt = 0;
    logic [9:0] got_mem [0:255];
    int         ovr_cnt = 0;
    int         busy_cyc = 0;
    int         val_cyc = 0;
    int         rise_cyc = 0;
    logic       valid_d = 1'b0;
    int         start_cyc = 0;

    uart_rx_controller #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .rx_serial(rx_serial), .parity_sel(parity_sel),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_error(parity_error), .frame_error(frame_error), .overrun(overrun),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: records every accepted byte and event counts.
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        valid_d <= rx_valid;
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                got_mem[got_cnt[7:0]] <= {frame_error, parity_error, rx_data};
                got_cnt <= got_cnt + 1;
            end
            if (rx_valid && !valid_d) rise_cyc <= cyc;
            if (rx_valid) val_cyc <= val_cyc + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (rx_busy) busy_cyc <= busy_cyc + 1;
        end
    end

    function automatic logic ref_parity(input logic [7:0] d, input logic [1:0] psel);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        case (psel)
            2'b01:   return logic'(ones % 2);
            2'b10:   return logic'(1 - ones % 2);
            default: return 1'b1;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_serial = v;
        step(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] psel,
                              input logic par_flip, input logic stop_v);
        parity_sel = psel;
        start_cyc  = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (psel != 2'b00) drive_bit(ref_parity(d, psel) ^ par_flip);
        drive_bit(stop_v);
    endtask

    task automatic wait_got(input int n, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (got_cnt >= n) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] d,
                               input logic pe, input logic fe);
        int   idx;
        logic ok;
        idx = got_cnt;
        wait_got(idx + 1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout got_cnt=%0d required=%0d", name, got_cnt, idx + 1);
        end else begin
            if (got_mem[idx] !== {fe, pe, d}) begin
                failures++;
                $display("FAIL %s got fe/pe/data=%b/%b/%h required=%b/%b/%h", name,
                         got_mem[idx][9], got_mem[idx][8], got_mem[idx][7:0], fe, pe, d);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(4);
        checks++;
        if ({rx_data, rx_valid, parity_error, frame_error, overrun, rx_busy} !== 13'h0) begin
            failures++;
            $display("FAIL reset_values got data=%h v=%b pe=%b fe=%b ovr=%b busy=%b required all 0",
                     rx_data, rx_valid, parity_error, frame_error, overrun, rx_busy);
        end
        reset = 1'b0;
        step(3 * BIT);
        checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b valid=%b required 0/0", rx_busy, rx_valid);
        end
    endtask

    task automatic test_basic;
        int v0;
        int lat;
        rx_ready = 1'b1;
        v0 = val_cyc;
        check_frame("basic_a5", 8'hA5, 1'b0, 1'b0);
        lat = rise_cyc - start_cyc;
        checks++;
        if (lat < BIT * 19 / 2 || lat > BIT * 19 / 2 + 16) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=%0d..%0d", lat, BIT * 19 / 2, BIT * 19 / 2 + 16);
        end
        checks++;
        if (val_cyc - v0 != 1) begin
            failures++;
            $display("FAIL basic_valid_cycles got=%0d required=1", val_cyc - v0);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_after got=%b required=0", rx_busy);
        end
    endtask

    task automatic test_parity;
        int lat;
        check_frame("parity_even_bad", 8'h37, 1'b1, 1'b0);
        lat = rise_cyc - start_cyc;
        checks++;
        if (lat < BIT * 21 / 2 || lat > BIT * 21 / 2 + 16) begin
            failures++;
            $display("FAIL parity_latency got=%0d required=%0d..%0d", lat, BIT * 21 / 2, BIT * 21 / 2 + 16);
        end
        step(BIT);
        check_frame("parity_even_good", 8'h37, 1'b0, 1'b0);
    endtask

    task automatic test_frame_error;
        check_frame("frame_err_55", 8'h55, 1'b0, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_frame("after_frame_err_0f", 8'h0F, 1'b0, 1'b0);
    endtask

    task automatic test_glitch;
        int g0;
        int b0;
        g0 = got_cnt;
        b0 = busy_cyc;
        rx_serial = 1'b0;
        step(12);
        rx_serial = 1'b1;
        step(2 * BIT);
        checks++;
        if (got_cnt != g0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_no_valid got_cnt_delta=%0d valid=%b required 0/0", got_cnt - g0, rx_valid);
        end
        checks++;
        if (busy_cyc - b0 <= 0 || busy_cyc - b0 > BIT || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy busy_cycles=%0d busy_now=%b required 1..%0d and 0",
                     busy_cyc - b0, rx_busy, BIT);
        end
    endtask

    task automatic test_back_to_back;
        int   g0;
        int   o0;
        rx_ready = 1'b0;
        g0 = got_cnt;
        o0 = ovr_cnt;
        send_frame(8'h11, 2'b00, 1'b0, 1'b1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b1);
        step(BIT);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            failures++;
            $display("FAIL b2b_hold valid=%b data=%h required 1/11", rx_valid, rx_data);
        end
        checks++;
        if (ovr_cnt - o0 != 1) begin
            failures++;
            $display("FAIL b2b_overrun_pulses got=%0d required=1", ovr_cnt - o0);
        end
        rx_ready = 1'b1;
        step(2);
        checks++;
        if (got_cnt - g0 != 1 || got_mem[g0] !== {2'b00, 8'h11}) begin
            failures++;
            $display("FAIL b2b_accept count=%0d entry=%h required 1/011", got_cnt - g0, got_mem[g0]);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_valid_drop got=%b required=0", rx_valid);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        int         g0;
        d = 8'hC3;
        parity_sel = 2'b00;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx_serial = d[3];
        step(BIT / 2);
        reset = 1'b1;
        #1;
        checks++;
        if ({rx_data, rx_valid, parity_error, frame_error, overrun, rx_busy} !== 13'h0) begin
            failures++;
            $display("FAIL midframe_reset got data=%h v=%b pe=%b fe=%b ovr=%b busy=%b required all 0",
                     rx_data, rx_valid, parity_error, frame_error, overrun, rx_busy);
        end
        step(5);
        reset = 1'b0;
        g0 = got_cnt;
        step(3 * BIT);
        checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || got_cnt != g0) begin
            failures++;
            $display("FAIL low_line_after_reset busy=%b valid=%b new=%0d required 0/0/0",
                     rx_busy, rx_valid, got_cnt - g0);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_frame("after_reset_3c", 8'h3C, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic [1:0] psel;
        logic       flip, stop_v;
        rx_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            d      = 8'($urandom);
            psel   = 2'($urandom);
            flip   = ($urandom_range(0, 3) == 0);
            stop_v = ($urandom_range(0, 4) != 0);
            fork
                send_frame(d, psel, flip, stop_v);
                check_frame("random", d, (psel != 2'b00) && flip, !stop_v);
            join
            rx_serial = 1'b1;
            step(BIT * $urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset;
        fork
            send_frame(8'hA5, 2'b00, 1'b0, 1'b1);
            test_basic;
        join
        step(BIT);
        fork
            begin
                send_frame(8'h37, 2'b01, 1'b1, 1'b1);
                step(BIT);
                send_frame(8'h37, 2'b01, 1'b0, 1'b1);
            end
            test_parity;
        join
        step(BIT);
        fork
            begin
                send_frame(8'h55, 2'b00, 1'b0, 1'b0);
                rx_serial = 1'b1;
                step(2 * BIT);
                send_frame(8'h0F, 2'b00, 1'b0, 1'b1);
            end
            test_frame_error;
        join
        step(BIT);
        test_glitch;
        test_back_to_back;
        step(BIT);
        fork
            test_reset_midframe;
            begin
                wait (reset === 1'b1);
                wait (reset === 1'b0);
                step(3 * BIT + 2 * BIT);
                send_frame(8'h3C, 2'b00, 1'b0, 1'b1);
            end
        join
        step(BIT);
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
